// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus tick-sampled debouncer for the board slide switches.
// Optional SWITCH_FREEZE_EN adds a freeze input that holds sw_clean and suppresses pulses.
module switch_debouncer #(
    parameter int WIDTH          = 16,
    parameter int TICK_DIV       = 100000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SWITCH_FREEZE_EN
    input  logic             freeze,
`endif
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_change
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [WIDTH-1:0]          sync_meta;
    logic [WIDTH-1:0]          sync_q;
    logic [CNT_W-1:0]          tick_count;
    logic                      tick;
    logic                      accept_en;
    logic [STABLE_SAMPLES-1:0] hist      [WIDTH];
    logic [STABLE_SAMPLES-1:0] hist_next [WIDTH];
    logic [WIDTH-1:0]          clean_next;
    logic [WIDTH-1:0]          rise_next;
    logic [WIDTH-1:0]          fall_next;

    assign tick = (tick_count == TICK_LAST);

`ifdef SWITCH_FREEZE_EN
    // History keeps qualifying while frozen; only acceptance is withheld.
    assign accept_en = tick & ~freeze;
`else
    assign accept_en = tick;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta  <= '0;
            sync_q     <= '0;
            tick_count <= '0;
        end else begin
            sync_meta  <= sw_raw;
            sync_q     <= sync_meta;
            tick_count <= tick ? '0 : tick_count + 1'b1;
        end
    end

    // Acceptance looks at the history including the sample taken this tick.
    always_comb begin
        clean_next = sw_clean;
        rise_next  = '0;
        fall_next  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hist_next[i] = hist[i];
            if (tick) begin
                hist_next[i] = {hist[i][STABLE_SAMPLES-2:0], sync_q[i]};
            end
            if (accept_en) begin
                if ((&hist_next[i]) && !sw_clean[i]) begin
                    clean_next[i] = 1'b1;
                    rise_next[i]  = 1'b1;
                end else if (!(|hist_next[i]) && sw_clean[i]) begin
                    clean_next[i] = 1'b0;
                    fall_next[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist[i] <= '0;
            end
            sw_clean  <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            sw_change <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                hist[i] <= hist_next[i];
            end
            sw_clean  <= clean_next;
            sw_rise   <= rise_next;
            sw_fall   <= fall_next;
            sw_change <= |(rise_next | fall_next);
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with TICK_DIV=4, STABLE_SAMPLES=3.
// Ticks land on every 4th clock edge after reset release; cyc counts those edges.
module tb_switch_debouncer;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_change;
`ifdef SWITCH_FREEZE_EN
    logic             freeze;
`endif

    int cyc;
    int check_cnt;
    int pass_cnt;
    int fail_cnt;
    int change_tot;
    int rise_tot;
    int fall_tot;
    int rise_cnt [WIDTH];
    int fall_cnt [WIDTH];
    int base;

    switch_debouncer #(
        .WIDTH         (WIDTH),
        .TICK_DIV      (4),
        .STABLE_SAMPLES(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SWITCH_FREEZE_EN
        .freeze   (freeze),
`endif
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .sw_change(sw_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle so each one-cycle pulse counts once.
    initial begin
        change_tot = 0;
        rise_tot   = 0;
        fall_tot   = 0;
        for (int k = 0; k < WIDTH; k++) begin
            rise_cnt[k] = 0;
            fall_cnt[k] = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (sw_change) change_tot++;
            for (int k = 0; k < WIDTH; k++) begin
                if (sw_rise[k]) begin
                    rise_cnt[k]++;
                    rise_tot++;
                end
                if (sw_fall[k]) begin
                    fall_cnt[k]++;
                    fall_tot++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] raw);
        sw_raw = raw;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s at cyc %0d: observed=%h expected=%h", tag, cyc, observed, expected);
        end
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        cyc       = 0;
        rst       = 1'b1;
`ifdef SWITCH_FREEZE_EN
        freeze    = 1'b0;
`endif
        applyStimulus(16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        checkOutput("reset_clean",  32'(sw_clean),  32'h0);
        checkOutput("reset_rise",   32'(sw_rise),   32'h0);
        checkOutput("reset_fall",   32'(sw_fall),   32'h0);
        checkOutput("reset_change", 32'(sw_change), 32'h0);

        stepTo(40);
        checkOutput("idle_clean",   32'(sw_clean), 32'h0);
        checkOutput("idle_changes", 32'(change_tot), 32'd0);
        checkOutput("idle_rises",   32'(rise_tot + fall_tot), 32'd0);

        // Step bit 0 just after edge 40: first sampling tick 44, accepted at 52.
        applyStimulus(16'h0001);
        stepTo(51);
        checkOutput("step_early_clean", 32'(sw_clean), 32'h0000);
        stepTo(52);
        checkOutput("step_clean",  32'(sw_clean),  32'h0001);
        checkOutput("step_rise",   32'(sw_rise),   32'h0001);
        checkOutput("step_fall",   32'(sw_fall),   32'h0000);
        checkOutput("step_change", 32'(sw_change), 32'h1);
        stepTo(53);
        checkOutput("step_rise_gone",   32'(sw_rise),   32'h0000);
        checkOutput("step_change_gone", 32'(sw_change), 32'h0);

        // Bit 3 sampled 1,0,1 at ticks 60/64/68, then stays 1 until 76.
        stepTo(56);
        applyStimulus(16'h0009);
        stepTo(60);
        applyStimulus(16'h0001);
        stepTo(64);
        applyStimulus(16'h0009);
        stepTo(75);
        checkOutput("bounce_early_clean", 32'(sw_clean), 32'h0001);
        stepTo(76);
        checkOutput("bounce_clean", 32'(sw_clean), 32'h0009);
        checkOutput("bounce_rise",  32'(sw_rise),  32'h0008);
        stepTo(80);
        checkOutput("bounce_rise_count", 32'(rise_cnt[3]), 32'd1);
        checkOutput("bounce_fall_count", 32'(fall_cnt[3]), 32'd0);
        checkOutput("bit0_rise_count",   32'(rise_cnt[0]), 32'd1);

        applyStimulus(16'h00FF);
        stepTo(91);
        checkOutput("low_byte_early", 32'(sw_clean), 32'h0009);
        stepTo(92);
        checkOutput("low_byte_clean", 32'(sw_clean), 32'h00FF);
        checkOutput("low_byte_rise",  32'(sw_rise),  32'h00F6);

        // Swap the bytes: rises and falls must land in the same cycle.
        stepTo(96);
        applyStimulus(16'hFF00);
        base = change_tot;
        stepTo(107);
        checkOutput("swap_early_clean", 32'(sw_clean), 32'h00FF);
        stepTo(108);
        checkOutput("swap_rise",   32'(sw_rise),   32'hFF00);
        checkOutput("swap_fall",   32'(sw_fall),   32'h00FF);
        checkOutput("swap_change", 32'(sw_change), 32'h1);
        checkOutput("swap_clean",  32'(sw_clean),  32'hFF00);
        stepTo(109);
        checkOutput("swap_change_gone", 32'(sw_change), 32'h0);
        stepTo(120);
        checkOutput("swap_change_count", 32'(change_tot - base), 32'd1);

        // Two stable ticks for bits 0-3, then reset between clock edges.
        applyStimulus(16'hFF0F);
        stepTo(129);
        checkOutput("prereset_clean", 32'(sw_clean), 32'hFF00);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_clean",  32'(sw_clean),  32'h0);
        checkOutput("async_reset_rise",   32'(sw_rise),   32'h0);
        checkOutput("async_reset_change", 32'(sw_change), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Switches high at release are accepted after three fresh ticks (4, 8, 12).
        stepTo(11);
        checkOutput("powerup_early_clean", 32'(sw_clean), 32'h0000);
        stepTo(12);
        checkOutput("powerup_clean",  32'(sw_clean),  32'hFF0F);
        checkOutput("powerup_rise",   32'(sw_rise),   32'hFF0F);
        checkOutput("powerup_change", 32'(sw_change), 32'h1);

`ifdef SWITCH_FREEZE_EN
        stepTo(16);
        freeze = 1'b1;
        applyStimulus(16'hFF1F);
        base = rise_tot;
        stepTo(36);
        checkOutput("freeze_clean",  32'(sw_clean), 32'hFF0F);
        checkOutput("freeze_pulses", 32'(rise_tot - base), 32'd0);
        freeze = 1'b0;
        stepTo(39);
        checkOutput("unfreeze_early_clean", 32'(sw_clean), 32'hFF0F);
        stepTo(40);
        checkOutput("unfreeze_clean",  32'(sw_clean),  32'hFF1F);
        checkOutput("unfreeze_rise",   32'(sw_rise),   32'h0010);
        checkOutput("unfreeze_change", 32'(sw_change), 32'h1);
        stepTo(41);
        checkOutput("unfreeze_rise_gone", 32'(sw_rise), 32'h0000);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
